// File: rtl/rx_frame_pkg.sv
// Shared definitions for the receive frame deframer: FSM states, error
// codes, default delimiter words and header field positions.
package rx_frame_pkg;

    // Deframer states, in the order a well-formed frame walks through them
    typedef enum logic [2:0] {
        HUNT,
        IDLE,
        HDR,
        PAYLOAD,
        EOF_CHK
    } rxState_e;

    // Error codes reported on o_err_code, held until the next error pulse
    localparam logic [1:0] ERR_BAD_LEN      = 2'd0;
    localparam logic [1:0] ERR_EOF_MISMATCH = 2'd1;
    localparam logic [1:0] ERR_LOCK_LOST    = 2'd2;
    localparam logic [1:0] ERR_REALIGN      = 2'd3;

    // Default delimiter and fill words; IDLE must agree with the bit aligner
    localparam logic [31:0] DEFAULT_SOF_WORD  = 32'hFB55_55D5;
    localparam logic [31:0] DEFAULT_EOF_WORD  = 32'hFDFD_FDFD;
    localparam logic [31:0] DEFAULT_IDLE_WORD = 32'h0707_0707;

    // Header word layout: {len[15:0], seq[15:0]}
    localparam int HDR_LEN_MSB = 31;
    localparam int HDR_LEN_LSB = 16;
    localparam int HDR_SEQ_MSB = 15;
    localparam int HDR_SEQ_LSB = 0;

    // A zero-length or oversize frame cannot be framed, so it is rejected at the header
    function automatic logic lenIsBad(input logic [15:0] len, input int maxLen);
        return (len == 16'd0) || (len > 16'(maxLen));
    endfunction

endpackage

// File: rtl/rx_frame_deframer.sv
// Receive frame deframer: strips IDLE fill, delimits SOF/header/payload/EOF
// frames from the aligned word stream, forwards payload with sof/eof markers
// and asks the bit aligner to realign after a run of unexpected words.
module rx_frame_deframer
    import rx_frame_pkg::*;
#(
    parameter int              W               = 32,
    parameter logic [W-1:0]    SOF_WORD        = DEFAULT_SOF_WORD,
    parameter logic [W-1:0]    EOF_WORD        = DEFAULT_EOF_WORD,
    parameter logic [W-1:0]    IDLE_WORD       = DEFAULT_IDLE_WORD,
    parameter int              MAX_LEN         = 1024,
    parameter int              BAD_WORD_MAX    = 16,
    parameter int              REALIGN_HOLDOFF = 64
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               i_bit_locked,
    input  logic               i_valid,
    input  logic [W-1:0]       i_data,
    output logic               o_valid,
    output logic [W-1:0]       o_data,
    output logic               o_sof,
    output logic               o_eof,
    output logic [15:0]        o_seq,
    output logic               o_frame_ok,
    output logic               o_err,
    output logic [1:0]         o_err_code,
    output logic               o_realign_req
);

    localparam int BCW = $clog2(BAD_WORD_MAX + 1);
    localparam int HOW = $clog2(REALIGN_HOLDOFF + 1);

    localparam logic [BCW-1:0] BAD_LAST    = BCW'(BAD_WORD_MAX - 1);
    localparam logic [HOW-1:0] HOLDOFF_VAL = HOW'(REALIGN_HOLDOFF);

    rxState_e        state_q;
    logic [15:0]     remaining_q;
    logic            firstWord_q;
    logic [15:0]     seqPend_q;
    logic [BCW-1:0]  badCnt_q;
    logic [HOW-1:0]  holdoff_q;

    logic            valid_q;
    logic [W-1:0]    data_q;
    logic            sof_q;
    logic            eof_q;
    logic [15:0]     seq_q;
    logic            frameOk_q;
    logic            err_q;
    logic [1:0]      errCode_q;
    logic            realign_q;

    logic [15:0]     hdrLen_d;
    logic [15:0]     hdrSeq_d;
    logic            hdrBad_d;
    logic            lockLost_d;
    logic            inFrame_d;

    // Decode the current word as a header and detect lock loss outside HUNT
    always_comb begin
        hdrLen_d   = i_data[HDR_LEN_MSB:HDR_LEN_LSB];
        hdrSeq_d   = i_data[HDR_SEQ_MSB:HDR_SEQ_LSB];
        hdrBad_d   = lenIsBad(hdrLen_d, MAX_LEN);
        lockLost_d = (state_q != HUNT) && !i_bit_locked;
        inFrame_d  = (state_q == HDR) || (state_q == PAYLOAD) || (state_q == EOF_CHK);
    end

    // Frame FSM with its counters and the registered output stage
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= HUNT;
            remaining_q <= '0;
            firstWord_q <= 1'b0;
            seqPend_q   <= '0;
            badCnt_q    <= '0;
            holdoff_q   <= '0;
            valid_q     <= 1'b0;
            data_q      <= '0;
            sof_q       <= 1'b0;
            eof_q       <= 1'b0;
            seq_q       <= '0;
            frameOk_q   <= 1'b0;
            err_q       <= 1'b0;
            errCode_q   <= ERR_BAD_LEN;
            realign_q   <= 1'b0;
        end else begin
            valid_q   <= 1'b0;
            sof_q     <= 1'b0;
            eof_q     <= 1'b0;
            frameOk_q <= 1'b0;
            err_q     <= 1'b0;
            realign_q <= 1'b0;

            if (lockLost_d) begin
                state_q  <= HUNT;
                badCnt_q <= '0;
                if (inFrame_d) begin
                    err_q     <= 1'b1;
                    errCode_q <= ERR_LOCK_LOST;
                end
            end else begin
                case (state_q)
                    HUNT: begin
                        if (holdoff_q != '0) begin
                            holdoff_q <= holdoff_q - 1'b1;
                        end else if (i_bit_locked) begin
                            state_q <= IDLE;
                        end
                    end

                    IDLE: begin
                        if (i_valid) begin
                            if (i_data == IDLE_WORD) begin
                                badCnt_q <= '0;
                            end else if (i_data == SOF_WORD) begin
                                badCnt_q <= '0;
                                state_q  <= HDR;
                            end else if (badCnt_q >= BAD_LAST) begin
                                badCnt_q  <= '0;
                                realign_q <= 1'b1;
                                err_q     <= 1'b1;
                                errCode_q <= ERR_REALIGN;
                                holdoff_q <= HOLDOFF_VAL;
                                state_q   <= HUNT;
                            end else begin
                                badCnt_q <= badCnt_q + 1'b1;
                            end
                        end
                    end

                    HDR: begin
                        if (i_valid) begin
                            if (hdrBad_d) begin
                                err_q     <= 1'b1;
                                errCode_q <= ERR_BAD_LEN;
                                state_q   <= IDLE;
                            end else begin
                                remaining_q <= hdrLen_d;
                                seqPend_q   <= hdrSeq_d;
                                firstWord_q <= 1'b1;
                                state_q     <= PAYLOAD;
                            end
                        end
                    end

                    PAYLOAD: begin
                        if (i_valid) begin
                            valid_q     <= 1'b1;
                            data_q      <= i_data;
                            sof_q       <= firstWord_q;
                            eof_q       <= (remaining_q == 16'd1);
                            firstWord_q <= 1'b0;
                            remaining_q <= remaining_q - 16'd1;
                            if (firstWord_q) begin
                                seq_q <= seqPend_q;
                            end
                            if (remaining_q == 16'd1) begin
                                state_q <= EOF_CHK;
                            end
                        end
                    end

                    EOF_CHK: begin
                        if (i_valid) begin
                            if (i_data == EOF_WORD) begin
                                frameOk_q <= 1'b1;
                            end else begin
                                err_q     <= 1'b1;
                                errCode_q <= ERR_EOF_MISMATCH;
                            end
                            state_q <= IDLE;
                        end
                    end

                    default: begin
                        state_q <= HUNT;
                    end
                endcase
            end
        end
    end

    assign o_valid       = valid_q;
    assign o_data        = data_q;
    assign o_sof         = sof_q;
    assign o_eof         = eof_q;
    assign o_seq         = seq_q;
    assign o_frame_ok    = frameOk_q;
    assign o_err         = err_q;
    assign o_err_code    = errCode_q;
    assign o_realign_req = realign_q;

endmodule

// File: tb/tb_rx_frame_deframer.sv
// Directed bench for the receive frame deframer: good frames, EOF mismatch,
// bad lengths, realign requests with holdoff, lock loss and valid gaps.
module tb_rx_frame_deframer;

    localparam logic [31:0] SOF  = 32'hFB55_55D5;
    localparam logic [31:0] EOFW = 32'hFDFD_FDFD;
    localparam logic [31:0] IDLW = 32'h0707_0707;
    localparam logic [31:0] BAD  = 32'hDEAD_BEEF;

    logic        clk;
    logic        rst_n;
    logic        i_bit_locked;
    logic        i_valid;
    logic [31:0] i_data;
    logic        o_valid;
    logic [31:0] o_data;
    logic        o_sof;
    logic        o_eof;
    logic [15:0] o_seq;
    logic        o_frame_ok;
    logic        o_err;
    logic [1:0]  o_err_code;
    logic        o_realign_req;

    int compareCount;
    int mismatchCount;

    rx_frame_deframer dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_bit_locked  (i_bit_locked),
        .i_valid       (i_valid),
        .i_data        (i_data),
        .o_valid       (o_valid),
        .o_data        (o_data),
        .o_sof         (o_sof),
        .o_eof         (o_eof),
        .o_seq         (o_seq),
        .o_frame_ok    (o_frame_ok),
        .o_err         (o_err),
        .o_err_code    (o_err_code),
        .o_realign_req (o_realign_req)
    );

    // Free-running 100 MHz clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Present one word for one clock and settle 1 ns after the edge
    task automatic applyStimulus(input logic v, input logic [31:0] d);
        i_valid = v;
        i_data  = d;
        @(posedge clk);
        #1;
    endtask

    // Single comparison point: counts and reports any disagreement
    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compareCount++;
        if (observed !== expected) begin
            mismatchCount++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
        end
    endtask

    // Check the registered outputs produced by the previously applied word
    task automatic checkWord(input string tag, input logic v, input logic [31:0] d,
                             input logic sof, input logic eof, input logic ok, input logic err);
        checkOutput({tag, ".valid"}, 32'(o_valid), 32'(v));
        if (v) begin
            checkOutput({tag, ".data"}, o_data, d);
        end
        checkOutput({tag, ".sof"}, 32'(o_sof), 32'(sof));
        checkOutput({tag, ".eof"}, 32'(o_eof), 32'(eof));
        checkOutput({tag, ".frame_ok"}, 32'(o_frame_ok), 32'(ok));
        checkOutput({tag, ".err"}, 32'(o_err), 32'(err));
    endtask

    // Send a whole well-formed frame of up to 4 words with seq, checking each output
    task automatic sendGoodFrame(input string tag, input int len, input logic [15:0] seq, input logic [31:0] base);
        applyStimulus(1'b1, SOF);
        checkWord({tag, ".sof_in"}, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, {16'(len), seq});
        checkWord({tag, ".hdr"}, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < len; i++) begin
            applyStimulus(1'b1, base + 32'(i));
            checkWord({tag, ".pay"}, 1'b1, base + 32'(i), (i == 0), (i == len - 1), 1'b0, 1'b0);
            checkOutput({tag, ".seq"}, 32'(o_seq), 32'(seq));
        end
        applyStimulus(1'b1, EOFW);
        checkWord({tag, ".eof_in"}, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0);
    endtask

    initial begin
        logic sawReq;
        compareCount  = 0;
        mismatchCount = 0;
        rst_n         = 1'b0;
        i_bit_locked  = 1'b0;
        i_valid       = 1'b0;
        i_data        = 32'h0;

        // Reset values
        repeat (3) applyStimulus(1'b0, 32'h0);
        checkWord("reset", 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("reset.seq", 32'(o_seq), 32'h0);
        checkOutput("reset.code", 32'(o_err_code), 32'h0);
        checkOutput("reset.realign", 32'(o_realign_req), 32'h0);

        // Test 1: lock, idle fill, good len=3 frame
        rst_n        = 1'b1;
        i_bit_locked = 1'b1;
        applyStimulus(1'b0, 32'h0);
        repeat (4) begin
            applyStimulus(1'b1, IDLW);
            checkWord("t1.idle", 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        end
        sendGoodFrame("t1", 3, 16'h00A5, 32'h1111_0000);

        // Test 2: EOF mismatch, then a good frame
        applyStimulus(1'b1, SOF);
        applyStimulus(1'b1, 32'h0003_00A5);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 32'h2222_0000 + 32'(i));
            checkWord("t2.pay", 1'b1, 32'h2222_0000 + 32'(i), (i == 0), (i == 2), 1'b0, 1'b0);
        end
        applyStimulus(1'b1, 32'h1234_5678);
        checkWord("t2.badeof", 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1);
        checkOutput("t2.code", 32'(o_err_code), 32'd1);
        sendGoodFrame("t2.next", 3, 16'h00A6, 32'h2323_0000);
        checkOutput("t2.code_held", 32'(o_err_code), 32'd1);

        // Test 3: len=0 and len=1025 rejected, then len=1 frame
        applyStimulus(1'b1, SOF);
        applyStimulus(1'b1, 32'h0000_0001);
        checkWord("t3.len0", 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1);
        checkOutput("t3.len0.code", 32'(o_err_code), 32'd0);
        applyStimulus(1'b1, 32'h3333_3333);
        checkWord("t3.len0.after", 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, SOF);
        applyStimulus(1'b1, 32'h0401_0002);
        checkWord("t3.len1025", 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1);
        checkOutput("t3.len1025.code", 32'(o_err_code), 32'd0);
        applyStimulus(1'b1, IDLW);
        sendGoodFrame("t3.len1", 1, 16'h0003, 32'hCAFE_F00D);

        // Test 4: 16 bad words trigger one realign request
        for (int i = 1; i <= 16; i++) begin
            applyStimulus(1'b1, BAD);
            checkOutput("t4.req", 32'(o_realign_req), 32'(i == 16));
        end
        checkOutput("t4.err", 32'(o_err), 32'd1);
        checkOutput("t4.code", 32'(o_err_code), 32'd3);
        sawReq = 1'b0;
        for (int i = 0; i < 70; i++) begin
            applyStimulus(1'b1, BAD);
            sawReq = sawReq | o_realign_req;
        end
        checkOutput("t4.holdoff_norepeat", 32'(sawReq), 32'd0);
        applyStimulus(1'b1, IDLW);
        sawReq = 1'b0;
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < 15; i++) begin
                applyStimulus(1'b1, BAD);
                sawReq = sawReq | o_realign_req;
            end
            applyStimulus(1'b1, IDLW);
            sawReq = sawReq | o_realign_req;
        end
        checkOutput("t4.15_idle_15", 32'(sawReq), 32'd0);
        sendGoodFrame("t4.after", 2, 16'h0044, 32'h4444_0000);

        // Test 5: lock lost on payload word 2 of a len=8 frame
        applyStimulus(1'b1, SOF);
        applyStimulus(1'b1, 32'h0008_0055);
        applyStimulus(1'b1, 32'h5555_0000);
        checkWord("t5.p0", 1'b1, 32'h5555_0000, 1'b1, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 32'h5555_0001);
        checkWord("t5.p1", 1'b1, 32'h5555_0001, 1'b0, 1'b0, 1'b0, 1'b0);
        i_bit_locked = 1'b0;
        applyStimulus(1'b1, 32'h5555_0002);
        checkWord("t5.lost", 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1);
        checkOutput("t5.code", 32'(o_err_code), 32'd2);
        for (int i = 3; i < 8; i++) begin
            applyStimulus(1'b1, 32'h5555_0000 + 32'(i));
            checkWord("t5.hunt", 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        end
        i_bit_locked = 1'b1;
        applyStimulus(1'b0, 32'h0);
        sendGoodFrame("t5.relock", 2, 16'h0056, 32'h5656_0000);
        checkOutput("t5.code_held", 32'(o_err_code), 32'd2);

        // Test 6: valid toggling every cycle over a len=4 frame
        applyStimulus(1'b1, SOF);
        applyStimulus(1'b0, EOFW);
        applyStimulus(1'b1, 32'h0004_0077);
        applyStimulus(1'b0, SOF);
        checkWord("t6.hdrgap", 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, 32'h6666_0000 + 32'(i));
            checkWord("t6.pay", 1'b1, 32'h6666_0000 + 32'(i), (i == 0), (i == 3), 1'b0, 1'b0);
            checkOutput("t6.seq", 32'(o_seq), 32'h0077);
            applyStimulus(1'b0, EOFW);
            checkWord("t6.gap", 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        end
        applyStimulus(1'b1, EOFW);
        checkWord("t6.eof_in", 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
        $finish;
    end

endmodule
